// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO: address-width helper and depth legality check.
package axis_fifo_pkg;

  localparam int MIN_DEPTH = 4;
  localparam int MAX_DEPTH = 256;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Register-array storage for the packet FIFO: one synchronous write port, one asynchronous read port.
module axis_fifo_mem
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH  = 33,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with in-band tlast, level/packet-count/almost-full status.
// Store-and-forward release is enabled by defining AXIS_PKT_FIFO_STORE_FWD_EN (cut-through otherwise).
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic                       almost_full,
  output logic                       oversize
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("axis_pkt_fifo: DEPTH must be a power of two in 4..256");
  end

  typedef struct packed {
    logic              tlast;
    logic [DATA_W-1:0] tdata;
  } beat_t;

  // Handshakes: a write beat transfers when s_tvalid && s_tready, a read beat when
  // m_tvalid && m_tready; s_tready depends only on state, and m_tvalid/m_tdata hold until taken.
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, r_pkt_count;
  logic             r_ready_en;
  logic [PTR_W-1:0] w_level;
  logic             w_empty, w_full, w_wr, w_rd, w_valid;
  beat_t            w_wr_beat, w_rd_beat;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == PTR_W'(DEPTH));
  assign w_wr      = s_tvalid && s_tready;
  assign w_rd      = w_valid && m_tready;
  assign w_wr_beat = '{tlast: s_tlast, tdata: s_tdata};

  axis_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_wr && !clear),
    .i_waddr(r_wr_ptr[ADDR_W-1:0]),
    .i_wdata(w_wr_beat),
    .i_raddr(r_rd_ptr[ADDR_W-1:0]),
    .o_rdata(w_rd_beat)
  );

  // r_ready_en keeps s_tready low while in reset and for nothing longer than the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pkt_count <= '0;
      r_ready_en  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (clear) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_pkt_count <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_wr && s_tlast, w_rd && w_rd_beat.tlast})
          2'b10:   r_pkt_count <= r_pkt_count + PTR_W'(1);
          2'b01:   r_pkt_count <= r_pkt_count - PTR_W'(1);
          default: r_pkt_count <= r_pkt_count;
        endcase
      end
    end
  end

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  logic r_oversize, r_cut;

  // A packet larger than the FIFO can never be held whole, so it is released cut-through
  // until its tlast beat leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oversize <= 1'b0;
      r_cut      <= 1'b0;
    end else if (clear) begin
      r_oversize <= 1'b0;
      r_cut      <= 1'b0;
    end else if (w_full && (r_pkt_count == '0)) begin
      r_oversize <= 1'b1;
      r_cut      <= 1'b1;
    end else if (w_rd && w_rd_beat.tlast) begin
      r_cut <= 1'b0;
    end
  end

  assign w_valid  = !w_empty && ((r_pkt_count != '0) || w_full || r_cut);
  assign oversize = r_oversize;
`else
  assign w_valid  = !w_empty;
  assign oversize = 1'b0;
`endif

  assign s_tready    = r_ready_en && !w_full;
  assign m_tvalid    = w_valid;
  assign m_tdata     = w_valid ? w_rd_beat.tdata : '0;
  assign m_tlast     = w_valid && w_rd_beat.tlast;
  assign level       = w_level;
  assign pkt_count   = r_pkt_count;
  assign almost_full = (w_level >= PTR_W'(AFULL_TH));

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo against a queue-based model of the FIFO contents.
module tb_axis_pkt_fifo;

  localparam int DW       = 32;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = DEPTH - 2;
  localparam int LW       = $clog2(DEPTH) + 1;

  // clock/reset and DUT signals
  logic          clk = 1'b0;
  logic          rst_n, clear;
  logic [DW-1:0] s_tdata, m_tdata;
  logic          s_tlast, s_tvalid, s_tready;
  logic          m_tlast, m_tvalid, m_tready;
  logic [LW-1:0] level, pkt_count;
  logic          almost_full, oversize;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .level(level), .pkt_count(pkt_count), .almost_full(almost_full), .oversize(oversize)
  );

  // scoreboard: expected contents as {tlast, tdata}, oldest first
  logic [DW:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit m_rdy_en = 1'b0;
  bit m_cut = 1'b0;
  bit m_ovs = 1'b0;

  function automatic int m_pkts();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][DW]) n++;
    return n;
  endfunction

  function automatic bit m_valid();
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    return (exp_q.size() > 0) && (m_pkts() > 0 || exp_q.size() == DEPTH || m_cut);
`else
    return exp_q.size() > 0;
`endif
  endfunction

  function automatic bit m_ready();
    return m_rdy_en && (exp_q.size() < DEPTH);
  endfunction

  // Advance one clock, applying the current inputs to the model; returns #1 after the edge.
  task automatic tick();
    bit acc, rd;
    logic [DW:0] b;
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    bit ovf;
    ovf = (exp_q.size() == DEPTH) && (m_pkts() == 0);
`endif
    acc = s_tvalid && m_ready();
    rd  = m_tready && m_valid();
    @(posedge clk);
    if (clear) begin
      exp_q.delete();
      m_cut = 1'b0;
      m_ovs = 1'b0;
    end else begin
      if (rd) begin
        b = exp_q.pop_front();
        if (b[DW]) m_cut = 1'b0;
      end
      if (acc) exp_q.push_back({s_tlast, s_tdata});
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      if (ovf) begin
        m_cut = 1'b1;
        m_ovs = 1'b1;
      end
`endif
    end
    m_rdy_en = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    m_rdy_en = 1'b0; m_cut = 1'b0; m_ovs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tdata !== '0 || m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_data got=%h/%b exp=0/0", m_tdata, m_tlast); end
    checks++; if (level !== '0 || pkt_count !== '0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", level, pkt_count); end
    checks++; if (almost_full !== 1'b0 || oversize !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b/%b exp=0/0", almost_full, oversize); end
    rst_n = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL release_s_tready got=%b exp=0", s_tready); end
    tick();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL first_cycle_s_tready got=%b exp=1", s_tready); end
  endtask

  task automatic test_fill_drain();
    m_tready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(i); s_tlast = (i == DEPTH);
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL fill_ready beat=%0d got=%b exp=1", i, s_tready); end
      tick();
      checks++; if (level !== LW'(i)) begin errors++; $display("FAIL fill_level got=%0d exp=%0d", level, i); end
      checks++; if (almost_full !== (i >= AFULL_TH)) begin errors++; $display("FAIL fill_afull level=%0d got=%b exp=%b", i, almost_full, i >= AFULL_TH); end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full_s_tready got=%b exp=0", s_tready); end
    m_tready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== DW'(i)) begin errors++; $display("FAIL drain_data got=%b/%h exp=1/%h", m_tvalid, m_tdata, i); end
      tick();
    end
    m_tready = 1'b0;
    checks++; if (level !== '0 || m_tvalid !== 1'b0 || m_tdata !== '0) begin errors++; $display("FAIL drain_empty got=%0d/%b/%h exp=0/0/0", level, m_tvalid, m_tdata); end
  endtask

  task automatic test_wrap();
    m_tready = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      s_tvalid = (i < 40);
      s_tdata  = $urandom;
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      s_tlast  = 1'b1;
`else
      s_tlast  = ($urandom_range(0, 3) == 0);
`endif
      if (i > 0) begin
        checks++; if (m_tvalid !== 1'b1 || exp_q.size() == 0 || {m_tlast, m_tdata} !== exp_q[0])
          begin errors++; $display("FAIL wrap_beat i=%0d got=%b/%h exp=1/%h", i, m_tvalid, {m_tlast, m_tdata}, exp_q.size() ? exp_q[0] : '0); end
      end
      tick();
      if (i < 40) begin
        checks++; if (level !== LW'(1)) begin errors++; $display("FAIL wrap_level i=%0d got=%0d exp=1", i, level); end
      end
    end
    idle_inputs();
    checks++; if (level !== '0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL wrap_end got=%0d/%b exp=0/0", level, m_tvalid); end
  endtask

  task automatic test_full_simul();
    int guard;
    m_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = (i == DEPTH - 1);
      tick();
    end
    s_tdata = 32'hCAFE_F00D; s_tlast = 1'b1; m_tready = 1'b1;
    checks++; if (s_tready !== 1'b0 || level !== LW'(DEPTH)) begin errors++; $display("FAIL simul_full got=%b/%0d exp=0/%0d", s_tready, level, DEPTH); end
    tick();
    m_tready = 1'b0;
    checks++; if (level !== LW'(DEPTH - 1) || s_tready !== 1'b1) begin errors++; $display("FAIL simul_after_read got=%0d/%b exp=%0d/1", level, s_tready, DEPTH - 1); end
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL simul_refill got=%0d exp=%0d", level, DEPTH); end
    m_tready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
      checks++; if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== exp_q[0]) begin errors++; $display("FAIL simul_drain got=%b/%h exp=1/%h", m_tvalid, {m_tlast, m_tdata}, exp_q[0]); end
      tick();
      guard++;
    end
    checks++; if (exp_q.size() != 0 || exp_q.size() != int'(level)) begin errors++; $display("FAIL simul_drain_done left=%0d level=%0d", exp_q.size(), level); end
    m_tready = 1'b0;
  endtask

  task automatic test_packets();
    int lens[3] = '{1, 3, 5};
    bit first;
    m_tready = 1'b0;
    foreach (lens[p]) begin
      for (int b = 0; b < lens[p]; b++) begin
        s_tvalid = 1'b1; s_tdata = {8'(p), 24'(b)}; s_tlast = (b == lens[p] - 1);
        tick();
      end
      checks++; if (pkt_count !== LW'(p + 1)) begin errors++; $display("FAIL pkt_inc got=%0d exp=%0d", pkt_count, p + 1); end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    first = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (first) begin
        checks++; if (m_tlast !== 1'b1) begin errors++; $display("FAIL single_beat_tlast got=%b exp=1", m_tlast); end
        first = 1'b0;
      end
      checks++; if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== exp_q[0]) begin errors++; $display("FAIL pkt_read got=%b/%h exp=1/%h", m_tvalid, {m_tlast, m_tdata}, exp_q[0]); end
      tick();
      checks++; if (pkt_count !== LW'(m_pkts())) begin errors++; $display("FAIL pkt_dec got=%0d exp=%0d", pkt_count, m_pkts()); end
    end
    m_tready = 1'b0;
  endtask

  task automatic test_clear();
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = $urandom_range(0, 1);
      tick();
    end
    checks++; if (level !== LW'(7)) begin errors++; $display("FAIL clear_pre_level got=%0d exp=7", level); end
    s_tdata = 32'hDEAD_BEEF; s_tlast = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (level !== '0 || pkt_count !== '0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL clear_state got=%0d/%0d/%b exp=0/0/0", level, pkt_count, m_tvalid); end
    tick();
    checks++; if (level !== '0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL clear_dropped got=%0d/%b exp=0/0", level, m_tvalid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      s_tvalid = $urandom_range(0, 1);
      s_tdata  = $urandom;
      s_tlast  = ($urandom_range(0, 3) == 0);
      m_tready = ($urandom_range(0, 2) != 0);
      clear    = ($urandom_range(0, 99) == 0);
      checks++; if (s_tready !== m_ready() || m_tvalid !== m_valid()) begin errors++; $display("FAIL rnd_hs i=%0d got=%b/%b exp=%b/%b", i, s_tready, m_tvalid, m_ready(), m_valid()); end
      if (m_valid()) begin
        checks++; if ({m_tlast, m_tdata} !== exp_q[0]) begin errors++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, {m_tlast, m_tdata}, exp_q[0]); end
      end
      checks++; if (level !== LW'(exp_q.size()) || pkt_count !== LW'(m_pkts())) begin errors++; $display("FAIL rnd_counts i=%0d got=%0d/%0d exp=%0d/%0d", i, level, pkt_count, exp_q.size(), m_pkts()); end
      checks++; if (almost_full !== (exp_q.size() >= AFULL_TH) || oversize !== m_ovs) begin errors++; $display("FAIL rnd_flags i=%0d got=%b/%b exp=%b/%b", i, almost_full, oversize, exp_q.size() >= AFULL_TH, m_ovs); end
      tick();
    end
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  task automatic test_store_fwd();
    int guard;
    m_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'h100 + i; s_tlast = 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL sf_hold cyc=%0d got=%b exp=0", i, m_tvalid); end
      tick();
    end
    s_tvalid = 1'b1; s_tdata = 32'h102; s_tlast = 1'b1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL sf_hold_tlast got=%b exp=0", m_tvalid); end
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h100) begin errors++; $display("FAIL sf_release got=%b/%h exp=1/100", m_tvalid, m_tdata); end
    repeat (3) tick();
    m_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'h200 + i; s_tlast = 1'b0;
      tick();
    end
    checks++; if (m_tvalid !== 1'b1 || oversize !== 1'b0) begin errors++; $display("FAIL sf_full got=%b/%b exp=1/0", m_tvalid, oversize); end
    s_tdata = 32'h200 + DEPTH;
    tick();
    checks++; if (oversize !== 1'b1) begin errors++; $display("FAIL sf_oversize got=%b exp=1", oversize); end
    m_tready = 1'b1;
    guard = 0;
    while ((exp_q.size() > 0 || s_tvalid) && guard < 100) begin
      checks++; if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== exp_q[0]) begin errors++; $display("FAIL sf_cut got=%b/%h exp=1/%h", m_tvalid, {m_tlast, m_tdata}, exp_q[0]); end
      tick();
      if (s_tvalid && exp_q.size() > 0 && exp_q[exp_q.size() - 1][DW-1:0] == s_tdata) begin
        if (s_tdata == 32'h200 + 19) s_tvalid = 1'b0;
        s_tdata = s_tdata + 1; s_tlast = (s_tdata == 32'h200 + 19);
      end
      guard++;
    end
    checks++; if (guard >= 100 || level !== '0) begin errors++; $display("FAIL sf_cut_done guard=%0d level=%0d exp=0", guard, level); end
    checks++; if (oversize !== 1'b1) begin errors++; $display("FAIL sf_sticky got=%b exp=1", oversize); end
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (oversize !== 1'b0) begin errors++; $display("FAIL sf_clear got=%b exp=0", oversize); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_packets();
    test_clear();
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    test_store_fwd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
